// File: rtl/flappy_pkg.sv
// Shared types and default geometry for the flappy-bird playfield blocks.
package flappy_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      FLY     = 2'd1,
      CRASHED = 2'd2
   } bird_state_t;

   localparam int ROWS      = 16;
   localparam int ROW_W     = 4;
   localparam int START_ROW = 8;

endpackage

// File: rtl/bird_physics_if.sv
// Control inputs and playfield outputs of the bird physics block.
interface bird_physics_if #(
   parameter int ROW_W = flappy_pkg::ROW_W
) ();

   logic             flap;
   logic             restart;
   logic [ROW_W-1:0] row;
   logic             crashed;
   logic             flying;

   modport master (
      output flap,
      output restart,
      input  row,
      input  crashed,
      input  flying
   );

   modport slave (
      input  flap,
      input  restart,
      output row,
      output crashed,
      output flying
   );

endinterface

// File: rtl/gravity_tick.sv
// Free-running divider that emits a one-cycle tick every DIV enabled cycles.
module gravity_tick #(
   parameter int DIV = 25000000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr_i,
   input  logic en_i,
   output logic tick_o
);

   localparam int            CW = (DIV > 2) ? $clog2(DIV) : 1;
   localparam logic [CW-1:0] TC = CW'(DIV - 1);

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   assign tick_o = en_i && (cnt_q == TC);

   // clear dominates enable so a flap restarts the gravity period cleanly
   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (en_i) begin
         cnt_d = tick_o ? '0 : cnt_q + CW'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/bird_physics.sv
// Bird vertical position: gravity at a fixed tick rate, flap lift, floor crash.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   IDLE    | waiting for first flap; row parked at START_ROW
//   FLY     | gravity active; flaps raise the bird, floor tick crashes
//   CRASHED | frozen at row 0 until restart
module bird_physics
   import flappy_pkg::*;
#(
   parameter int ROWS      = flappy_pkg::ROWS,
   parameter int ROW_W     = flappy_pkg::ROW_W,
   parameter int TICK_DIV  = 25000000,
   parameter int FLAP_ROWS = 2,
   parameter int START_ROW = flappy_pkg::START_ROW
) (
   input  logic           clk,
   input  logic           rst_n,
   bird_physics_if.slave  bus
);

   localparam logic [ROW_W-1:0] ROW_TOP   = ROW_W'(ROWS - 1);
   localparam logic [ROW_W-1:0] ROW_START = ROW_W'(START_ROW);
   localparam logic [ROW_W:0]   FLAP_INC  = (ROW_W + 1)'(FLAP_ROWS);

   bird_state_t      state_q;
   bird_state_t      state_d;
   logic [ROW_W-1:0] row_q;
   logic [ROW_W-1:0] row_d;
   logic             flying_q;
   logic             crashed_q;
   logic [ROW_W:0]   row_up;
   logic             tick;
   logic             tick_clr;
   logic             tick_en;

   assign row_up   = {1'b0, row_q} + FLAP_INC;
   assign tick_en  = (state_q == FLY);
   assign tick_clr = (state_q != FLY) || bus.flap;

   gravity_tick #(
      .DIV (TICK_DIV)
   ) u_gravity_tick (
      .clk    (clk),
      .rst_n  (rst_n),
      .clr_i  (tick_clr),
      .en_i   (tick_en),
      .tick_o (tick)
   );

   always_comb begin
      state_d = state_q;
      row_d   = row_q;
      unique case (state_q)
         IDLE: begin
            row_d = ROW_START;
            if (bus.flap) begin
               state_d = FLY;
            end
         end
         FLY: begin
            // a flap on a tick edge suppresses that tick's gravity step
            if (bus.flap) begin
               row_d = (row_up > {1'b0, ROW_TOP}) ? ROW_TOP : row_up[ROW_W-1:0];
            end else if (tick) begin
               if (row_q != '0) begin
                  row_d = row_q - ROW_W'(1);
               end else begin
                  state_d = CRASHED;
               end
            end
         end
         CRASHED: begin
            if (bus.restart) begin
               state_d = IDLE;
               row_d   = ROW_START;
            end
         end
         default: begin
            state_d = IDLE;
            row_d   = ROW_START;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         row_q     <= ROW_START;
         flying_q  <= 1'b0;
         crashed_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         row_q     <= row_d;
         flying_q  <= (state_d == FLY);
         crashed_q <= (state_d == CRASHED);
      end
   end

   assign bus.row     = row_q;
   assign bus.flying  = flying_q;
   assign bus.crashed = crashed_q;

endmodule

// File: tb/tb_bird_physics.sv
// Scoreboard bench for bird_physics with a short gravity period.
module tb_bird_physics;

   localparam int TDIV = 4;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   always #5 clk = ~clk;

   bird_physics_if #(.ROW_W(4)) bus ();

   bird_physics #(
      .ROWS      (16),
      .ROW_W     (4),
      .TICK_DIV  (TDIV),
      .FLAP_ROWS (2),
      .START_ROW (8)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   typedef struct {
      int row;
      bit fly;
      bit crash;
   } exp_t;

   exp_t sb_q[$];

   int n_total = 0;
   int n_bad   = 0;

   // reference model: 0 = idle, 1 = flying, 2 = crashed
   int m_state;
   int m_row;
   int m_cnt;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      m_state = 0;
      m_row   = 8;
      m_cnt   = 0;
   endtask

   task automatic model_step(input bit f, input bit r);
      case (m_state)
         0: begin
            m_row = 8;
            m_cnt = 0;
            if (f) m_state = 1;
         end
         1: begin
            if (f) begin
               m_row = (m_row + 2 > 15) ? 15 : m_row + 2;
               m_cnt = 0;
            end else if (m_cnt == TDIV - 1) begin
               m_cnt = 0;
               if (m_row == 0) m_state = 2;
               else            m_row   = m_row - 1;
            end else begin
               m_cnt = m_cnt + 1;
            end
         end
         default: begin
            m_cnt = 0;
            if (r) begin
               m_state = 0;
               m_row   = 8;
            end
         end
      endcase
   endtask

   task automatic step(input bit f, input bit r);
      exp_t e;
      bus.flap    = f;
      bus.restart = r;
      model_step(f, r);
      e.row   = m_row;
      e.fly   = (m_state == 1);
      e.crash = (m_state == 2);
      sb_q.push_back(e);
      @(posedge clk);
      #1;
      bus.flap    = 1'b0;
      bus.restart = 1'b0;
      e = sb_q.pop_front();
      chk("sb_row",     32'(bus.row),     32'(e.row));
      chk("sb_flying",  32'(bus.flying),  32'(e.fly));
      chk("sb_crashed", 32'(bus.crashed), 32'(e.crash));
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 1'b0);
   endtask

   initial begin
      bus.flap    = 1'b0;
      bus.restart = 1'b0;
      model_reset();
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_row",     32'(bus.row),     32'd8);
      chk("rst_flying",  32'(bus.flying),  32'd0);
      chk("rst_crashed", 32'(bus.crashed), 32'd0);
      rst_n = 1'b1;

      idle(20);

      step(1'b1, 1'b0);
      chk("start_flying", 32'(bus.flying), 32'd1);
      chk("start_row",    32'(bus.row),    32'd8);
      idle(4);
      chk("first_drop", 32'(bus.row), 32'd7);
      idle(4);
      chk("second_drop", 32'(bus.row), 32'd6);

      repeat (4) step(1'b1, 1'b0);
      chk("row14", 32'(bus.row), 32'd14);
      step(1'b1, 1'b0);
      chk("sat_once", 32'(bus.row), 32'd15);
      step(1'b1, 1'b0);
      chk("sat_twice", 32'(bus.row), 32'd15);

      idle(40);
      chk("row5", 32'(bus.row), 32'd5);
      idle(3);
      step(1'b1, 1'b0);
      chk("flap_beats_tick", 32'(bus.row), 32'd7);
      idle(3);
      chk("hold_after_flap", 32'(bus.row), 32'd7);
      idle(1);
      chk("drop_after_flap", 32'(bus.row), 32'd6);

      for (int i = 0; i < 200 && m_state != 2; i++) step(1'b0, 1'b0);
      chk("crash_flag",   32'(bus.crashed), 32'd1);
      chk("crash_flying", 32'(bus.flying),  32'd0);
      chk("crash_row",    32'(bus.row),     32'd0);

      repeat (3) step(1'b1, 1'b0);
      chk("crash_ignores_flap", 32'(bus.crashed), 32'd1);
      chk("crash_row_frozen",   32'(bus.row),     32'd0);

      step(1'b1, 1'b1);
      chk("restart_row",     32'(bus.row),     32'd8);
      chk("restart_flying",  32'(bus.flying),  32'd0);
      chk("restart_crashed", 32'(bus.crashed), 32'd0);
      idle(5);

      step(1'b1, 1'b0);
      idle(20);
      chk("fall_row3", 32'(bus.row), 32'd3);
      idle(2);
      #2;
      rst_n = 1'b0;
      #1;
      chk("async_row",     32'(bus.row),     32'd8);
      chk("async_flying",  32'(bus.flying),  32'd0);
      chk("async_crashed", 32'(bus.crashed), 32'd0);
      model_reset();
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      idle(3);
      step(1'b1, 1'b0);
      idle(4);
      chk("post_reset_drop", 32'(bus.row), 32'd7);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule

// File: doc/bird_physics.md
Name: bird_physics

Overview:
- Downstream consumer of the one-cycle flap pulse from the button-release stage.
- Holds the bird's vertical row on the LED playfield and applies gravity at a fixed tick rate.
- On each flap pulse, raises the bird by a fixed number of rows.
- Detects a floor crash and freezes until restarted; feeds the display/collision logic.

Parameters:
- ROWS, 16, playfield height in rows; row 0 = bottom.
- ROW_W, 4, width of row output; must satisfy 2**ROW_W >= ROWS.
- TICK_DIV, 25000000, Clock cycles per gravity tick; must be >= 2.
- FLAP_ROWS, 2, rows gained per flap.
- START_ROW, 8, row loaded on reset and on restart.

Ports:
- Clock, in, 1, system clock; all state on posedge.
- Reset, in, 1, asynchronous, active-low (0 = reset); takes effect immediately regardless of Clock.
- flap, in, 1, single-cycle pulse from the button-release stage; a wider pulse counts once per cycle high.
- restart, in, 1, level; returns the block from CRASHED to IDLE.
- row, out, ROW_W, current bird row, registered.
- crashed, out, 1, high while in CRASHED, registered.
- flying, out, 1, high while in FLY; gates pipe scrolling downstream.

Behaviour:
- Reset (Reset=0): state=IDLE, row=START_ROW, crashed=0, flying=0, tick counter=0.
- All outputs are registered; an input sampled at edge N is visible after edge N.
- State IDLE:
  - row held at START_ROW; tick counter held at 0.
  - flap=1 -> FLY; row unchanged (the first flap only starts the game); counter cleared.
- State FLY:
  - Tick counter counts 0..TICK_DIV-1 and wraps; a tick occurs on the edge where counter==TICK_DIV-1.
  - flap=1:
    - row <= min(row+FLAP_ROWS, ROWS-1), saturating at the ceiling with no wrap; compute at ROW_W+1 bits.
    - counter <= 0.
    - flap beats a coincident tick: no gravity that cycle.
  - tick, no flap, row>0: row <= row-1.
  - tick, no flap, row==0: state <= CRASHED; row stays 0.
  - restart in FLY: ignored.
- State CRASHED:
  - row frozen; crashed=1; flap ignored; counter held at 0.
  - restart=1 -> IDLE, row <= START_ROW.
  - restart and flap in the same cycle: restart wins; flap is dropped.
- flying=1 exactly when state==FLY; crashed=1 exactly when state==CRASHED.
- Reset asserted mid-tick or mid-flight: immediate return to reset values; no partial update survives.
- Row never exceeds ROWS-1 and never underflows below 0.

Decomposition:
- Shared package flappy_pkg:
  - bird_state_t enum {IDLE, FLY, CRASHED};
  - default constants ROWS, ROW_W, START_ROW.
- One sub-module: gravity_tick.
  - Parameterised divider with clear and enable inputs.
  - Output: one-cycle tick pulse.
  - Reused later for pipe scroll timing.

Test Plan (TICK_DIV=4, ROWS=16, FLAP_ROWS=2, START_ROW=8):
- Reset low 2 cycles, then high, no flap for 20 cycles -> row=8, flying=0, crashed=0 throughout.
- flap pulse in IDLE, then no input -> flying=1 next cycle, row=8; row=7 four cycles later, then decrements by 1 every 4 cycles.
- In FLY at row=14, flap -> row=15 (saturated); a second flap -> row stays 15.
- In FLY, flap on the same edge as a tick at row=5 -> row=7, and the next decrement occurs 4 cycles later.
- Let the bird fall to row=0, then wait one more tick -> crashed=1, flying=0, row=0; flaps ignored; restart -> IDLE with row=8 next cycle.
- Reset asserted asynchronously mid-counter with row=3 in FLY -> outputs immediately row=8, flying=0, crashed=0.
